// File: rtl/cam_capture_scaler.sv
// Camera RGB565 byte stream to 8-bit frame-buffer writes, with selectable pixel
// format, power-of-two decimation, window clipping and single/continuous arming.
module cam_capture_scaler #(
   parameter int AW           = 17,
   parameter int CAM_SCREEN_X = 160,
   parameter int CAM_SCREEN_Y = 120
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_vsync,
   input  logic          i_href,
   input  logic [7:0]    i_px_data,
   input  logic [1:0]    i_mode,
   input  logic [1:0]    i_dec,
   input  logic          i_capture_en,
   input  logic          i_single_shot,
   output logic [AW-1:0] o_mem_px_addr,
   output logic [7:0]    o_mem_px_data,
   output logic          o_px_wr,
   output logic          o_frame_done,
   output logic          o_busy,
   output logic [7:0]    o_frame_cnt,
   output logic          o_line_err
);

   localparam logic [15:0]   LP_X16 = 16'(CAM_SCREEN_X);
   localparam logic [15:0]   LP_Y16 = 16'(CAM_SCREEN_Y);
   localparam logic [AW-1:0] LP_XAW = AW'(CAM_SCREEN_X);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_VS = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_vsync_d;
   logic            r_href_d;
   logic            r_one_shot;
   logic            r_phase;
   logic [7:0]      r_hi;
   logic [1:0]      r_mode;
   logic [1:0]      r_dec_sh;
   logic [15:0]     r_src_x;
   logic [15:0]     r_src_y;
   logic [AW-1:0]   r_row_base;
   logic            r_px_wr;
   logic [AW-1:0]   r_addr;
   logic [7:0]      r_data;
   logic            r_frame_done;
   logic            r_busy;
   logic [7:0]      r_frame_cnt;
   logic            r_line_err;

   logic            w_frame_start;
   logic            w_frame_end;
   logic            w_in_cap;
   logic            w_href_rise;
   logic            w_href_fall;
   logic            w_phase;
   logic            w_byte_ok;
   logic            w_keep;
   logic            w_row_step;
   logic [15:0]     w_mask;
   logic [15:0]     w_col;
   logic [15:0]     w_row;
   logic [AW-1:0]   w_addr;

   function automatic logic [7:0] f_convert(input logic [1:0] mode, input logic [15:0] pix);
      logic [9:0] sum;
      logic [7:0] res;
      sum = {2'b00, pix[15:11], pix[15:13]} + {1'b0, pix[10:5], pix[10:9], 1'b0}
          + {2'b00, pix[4:0], pix[4:2]};
      case (mode)
         2'b01:   res = sum[9:2];
         2'b10:   res = pix[15:8];
         default: res = {pix[15:13], pix[10:8], pix[4:3]};
      endcase
      return res;
   endfunction

   assign w_frame_start = r_vsync_d & ~i_vsync;
   assign w_frame_end   = ~r_vsync_d & i_vsync;
   assign w_in_cap      = (r_state == S_CAPTURE);
   assign w_href_rise   = i_href & ~r_href_d;
   assign w_href_fall   = r_href_d & ~i_href;
   assign w_phase       = w_href_rise ? 1'b0 : r_phase;
   assign w_byte_ok     = w_in_cap & ~w_frame_end & i_href;
   assign w_col         = r_src_x >> r_dec_sh;
   assign w_row         = r_src_y >> r_dec_sh;
   assign w_addr        = r_row_base + AW'(w_col);
   assign w_row_step    = (((r_src_y + 16'd1) & w_mask) == 16'd0);

   always_comb begin
      w_mask = 16'd0;
      case (r_dec_sh)
         2'd0:    w_mask = 16'd0;
         2'd1:    w_mask = 16'd1;
         default: w_mask = 16'd3;
      endcase
      w_keep = ((r_src_x & w_mask) == 16'd0) && ((r_src_y & w_mask) == 16'd0)
            && (w_col < LP_X16) && (w_row < LP_Y16);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_capture_en || i_single_shot) w_next = S_WAIT_VS;
            else                               w_next = S_IDLE;
         end
         S_WAIT_VS: begin
            if (w_frame_start) w_next = S_CAPTURE;
            else               w_next = S_WAIT_VS;
         end
         S_CAPTURE: begin
            if (w_frame_end) w_next = S_DONE;
            else             w_next = S_CAPTURE;
         end
         S_DONE: begin
            if (i_capture_en && !r_one_shot) w_next = S_WAIT_VS;
            else                             w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Byte assembly, decimation/clipping, incremental addressing and status.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vsync_d    <= 1'b0;
         r_href_d     <= 1'b0;
         r_one_shot   <= 1'b0;
         r_phase      <= 1'b0;
         r_hi         <= 8'd0;
         r_mode       <= 2'd0;
         r_dec_sh     <= 2'd0;
         r_src_x      <= 16'd0;
         r_src_y      <= 16'd0;
         r_row_base   <= '0;
         r_px_wr      <= 1'b0;
         r_addr       <= '0;
         r_data       <= 8'd0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_cnt  <= 8'd0;
         r_line_err   <= 1'b0;
      end else begin
         r_vsync_d    <= i_vsync;
         r_href_d     <= i_href;
         r_px_wr      <= 1'b0;
         r_frame_done <= (w_next == S_DONE);
         r_busy       <= (w_next == S_WAIT_VS) || (w_next == S_CAPTURE);

         if (r_state == S_IDLE && w_next == S_WAIT_VS) begin
            r_one_shot <= i_single_shot;
         end else if (r_state == S_DONE) begin
            r_one_shot <= 1'b0;
         end

         if (r_state == S_WAIT_VS && w_frame_start) begin
            r_mode     <= i_mode;
            case (i_dec)
               2'b00:   r_dec_sh <= 2'd0;
               2'b01:   r_dec_sh <= 2'd1;
               default: r_dec_sh <= 2'd2;
            endcase
            r_line_err <= 1'b0;
            r_src_x    <= 16'd0;
            r_src_y    <= 16'd0;
            r_row_base <= '0;
            r_phase    <= 1'b0;
         end

         // A half-assembled pixel at frame end is simply dropped.
         if (w_in_cap && w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_phase     <= 1'b0;
         end

         if (w_byte_ok) begin
            if (!w_phase) begin
               r_hi    <= i_px_data;
               r_phase <= 1'b1;
            end else begin
               r_phase <= 1'b0;
               r_src_x <= r_src_x + 16'd1;
               if (w_keep) begin
                  r_px_wr <= 1'b1;
                  r_addr  <= w_addr;
                  r_data  <= f_convert(r_mode, {r_hi, i_px_data});
               end
            end
         end else if (w_in_cap && !w_frame_end && w_href_fall) begin
            r_src_y <= r_src_y + 16'd1;
            r_src_x <= 16'd0;
            r_phase <= 1'b0;
            if (r_phase) begin
               r_line_err <= 1'b1;
            end
            if (w_row_step) begin
               r_row_base <= r_row_base + LP_XAW;
            end
         end
      end
   end

   assign o_mem_px_addr = r_addr;
   assign o_mem_px_data = r_data;
   assign o_px_wr       = r_px_wr;
   assign o_frame_done  = r_frame_done;
   assign o_busy        = r_busy;
   assign o_frame_cnt   = r_frame_cnt;
   assign o_line_err    = r_line_err;

endmodule
